// File: rtl/biriscv_branch_resolve_pkg.sv
// Shared types for branch resolution and the next-PC predictor:
// the queued branch entry plus BTB/RAS encodings used by biriscv_npc.
package biriscv_branch_resolve_pkg;

  typedef struct packed {
    logic [31:0] source;
    logic [31:0] target;
    logic        taken;
    logic        mispredict;
    logic        is_call;
    logic        is_ret;
    logic        is_jmp;
  } br_entry_t;

  localparam int unsigned BR_ENTRY_W = $bits(br_entry_t);

  typedef enum logic [1:0] {
    BTB_TYPE_BRANCH = 2'd0,
    BTB_TYPE_JMP    = 2'd1,
    BTB_TYPE_CALL   = 2'd2,
    BTB_TYPE_RET    = 2'd3
  } btb_type_e;

  typedef enum logic [1:0] {
    RAS_OP_NONE = 2'd0,
    RAS_OP_PUSH = 2'd1,
    RAS_OP_POP  = 2'd2
  } ras_op_e;

  // A taken branch with the right direction can still land on the wrong target.
  function automatic logic is_mispredict(input logic        taken,
                                         input logic        pred_taken,
                                         input logic [31:0] target,
                                         input logic [31:0] pred_target);
    return (taken != pred_taken) || (taken && (target != pred_target));
  endfunction

  function automatic logic [31:0] next_pc(input logic        taken,
                                          input logic [31:0] target,
                                          input logic [31:0] source);
    return taken ? target : (source + 32'd4);
  endfunction

endpackage

// File: rtl/biriscv_branch_resolve_fifo.sv
// Two-write / one-read entry FIFO. Write port 0 is always the older entry;
// port 1 is only used together with port 0.
module biriscv_branch_resolve_fifo
  import biriscv_branch_resolve_pkg::*;
#(
  parameter int DEPTH   = 4,
  parameter int DEPTH_W = 2
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             flush_i,
  input  logic             push0_i,
  input  br_entry_t        data0_i,
  input  logic             push1_i,
  input  br_entry_t        data1_i,
  input  logic             pop_i,
  output br_entry_t        head_o,
  output logic [DEPTH_W:0] count_o
);

  localparam logic [DEPTH_W-1:0] PTR_ONE = DEPTH_W'(1);

  br_entry_t          mem_q [DEPTH];
  logic [DEPTH_W-1:0] wr_ptr_q;
  logic [DEPTH_W-1:0] rd_ptr_q;
  logic [DEPTH_W-1:0] wr_ptr_1;
  logic [DEPTH_W:0]   count_q;

  assign wr_ptr_1 = wr_ptr_q + PTR_ONE;

  // Storage needs no reset: occupancy alone decides what is valid.
  always_ff @(posedge clk_i) begin
    if (push0_i && !flush_i) mem_q[wr_ptr_q] <= data0_i;
    if (push1_i && !flush_i) mem_q[wr_ptr_1] <= data1_i;
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else if (flush_i) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_q + DEPTH_W'(push0_i) + DEPTH_W'(push1_i);
      rd_ptr_q <= rd_ptr_q + DEPTH_W'(pop_i);
      count_q  <= count_q + (DEPTH_W+1)'(push0_i) + (DEPTH_W+1)'(push1_i)
                  - (DEPTH_W+1)'(pop_i);
    end
  end

  assign head_o  = mem_q[rd_ptr_q];
  assign count_o = count_q;

endmodule

// File: rtl/biriscv_branch_resolve.sv
// Merges resolved branches from both execute pipes into one in-order
// training stream for the next-PC predictor and raises fetch redirects.
module biriscv_branch_resolve
  import biriscv_branch_resolve_pkg::*;
#(
  parameter int DEPTH   = 4,
  parameter int DEPTH_W = 2
) (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        flush_i,
  input  logic        res_a_valid_i,
  input  logic [31:0] res_a_source_i,
  input  logic [31:0] res_a_target_i,
  input  logic        res_a_taken_i,
  input  logic        res_a_pred_taken_i,
  input  logic [31:0] res_a_pred_target_i,
  input  logic        res_a_is_call_i,
  input  logic        res_a_is_ret_i,
  input  logic        res_a_is_jmp_i,
  input  logic        res_b_valid_i,
  input  logic [31:0] res_b_source_i,
  input  logic [31:0] res_b_target_i,
  input  logic        res_b_taken_i,
  input  logic        res_b_pred_taken_i,
  input  logic [31:0] res_b_pred_target_i,
  input  logic        res_b_is_call_i,
  input  logic        res_b_is_ret_i,
  input  logic        res_b_is_jmp_i,
  output logic        stall_o,
  output logic        redirect_o,
  output logic [31:0] redirect_pc_o,
  output logic        branch_request_o,
  output logic        branch_is_taken_o,
  output logic        branch_is_not_taken_o,
  output logic [31:0] branch_source_o,
  output logic [31:0] branch_pc_o,
  output logic        branch_is_call_o,
  output logic        branch_is_ret_o,
  output logic        branch_is_jmp_o,
  output logic [31:0] mispredict_count_o
);

  // Handshake: resolves are valid-only. The producer must hold off while
  // stall_o is high (anything offered then is dropped); the predictor side
  // has no ready and takes one entry per cycle whenever a strobe is high.

  br_entry_t        ent_a, ent_b, in0, fifo_wdata0, fifo_head, out_q;
  logic             misp_a, misp_b;
  logic             accept, acc_a, acc_b;
  logic             in0_valid, in1_valid;
  logic             fifo_empty, fifo_push0, fifo_push1, fifo_pop;
  logic [DEPTH_W:0] fifo_count;
  logic             out_valid_q;
  logic             redirect_d, redirect_q;
  logic [31:0]      redirect_pc_d, redirect_pc_q;
  logic [31:0]      mispredict_count_q;

  assign misp_a = is_mispredict(res_a_taken_i, res_a_pred_taken_i,
                                res_a_target_i, res_a_pred_target_i);
  assign misp_b = is_mispredict(res_b_taken_i, res_b_pred_taken_i,
                                res_b_target_i, res_b_pred_target_i);

  assign ent_a = '{source: res_a_source_i, target: res_a_target_i,
                   taken: res_a_taken_i, mispredict: misp_a,
                   is_call: res_a_is_call_i, is_ret: res_a_is_ret_i,
                   is_jmp: res_a_is_jmp_i};
  assign ent_b = '{source: res_b_source_i, target: res_b_target_i,
                   taken: res_b_taken_i, mispredict: misp_b,
                   is_call: res_b_is_call_i, is_ret: res_b_is_ret_i,
                   is_jmp: res_b_is_jmp_i};

  // B sits on the wrong path when the older A mispredicts.
  assign accept = !flush_i && !stall_o;
  assign acc_a  = accept && res_a_valid_i;
  assign acc_b  = accept && res_b_valid_i && !(res_a_valid_i && misp_a);

  // Compact the accepted pair so slot 0 always holds the oldest entry.
  assign in0_valid = acc_a || acc_b;
  assign in1_valid = acc_a && acc_b;
  assign in0       = acc_a ? ent_a : ent_b;

  assign fifo_empty  = (fifo_count == '0);
  assign fifo_pop    = !fifo_empty;
  assign fifo_push0  = fifo_empty ? in1_valid : in0_valid;
  assign fifo_wdata0 = fifo_empty ? ent_b : in0;
  assign fifo_push1  = !fifo_empty && in1_valid;

  biriscv_branch_resolve_fifo #(
    .DEPTH  (DEPTH),
    .DEPTH_W(DEPTH_W)
  ) u_fifo (
    .clk_i  (clk_i),
    .rst_i  (rst_i),
    .flush_i(flush_i),
    .push0_i(fifo_push0),
    .data0_i(fifo_wdata0),
    .push1_i(fifo_push1),
    .data1_i(ent_b),
    .pop_i  (fifo_pop),
    .head_o (fifo_head),
    .count_o(fifo_count)
  );

  assign stall_o = (fifo_count > (DEPTH_W+1)'(DEPTH - 2));

  assign redirect_d    = (acc_a && misp_a) || (acc_b && misp_b);
  assign redirect_pc_d = (acc_a && misp_a)
                         ? next_pc(res_a_taken_i, res_a_target_i, res_a_source_i)
                         : next_pc(res_b_taken_i, res_b_target_i, res_b_source_i);

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      redirect_q    <= 1'b0;
      redirect_pc_q <= '0;
    end else begin
      redirect_q <= redirect_d;
      if (redirect_d) redirect_pc_q <= redirect_pc_d;
    end
  end

  // Output stage: FIFO head has priority; an empty FIFO lets the oldest
  // new entry through directly. Data is held when nothing is emitted.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      out_valid_q <= 1'b0;
      out_q       <= '0;
    end else if (flush_i) begin
      out_valid_q <= 1'b0;
    end else if (!fifo_empty) begin
      out_valid_q <= 1'b1;
      out_q       <= fifo_head;
    end else if (in0_valid) begin
      out_valid_q <= 1'b1;
      out_q       <= in0;
    end else begin
      out_valid_q <= 1'b0;
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      mispredict_count_q <= '0;
    end else if (redirect_d && (mispredict_count_q != 32'hFFFF_FFFF)) begin
      mispredict_count_q <= mispredict_count_q + 32'd1;
    end
  end

  assign redirect_o            = redirect_q;
  assign redirect_pc_o         = redirect_pc_q;
  assign branch_request_o      = out_valid_q && out_q.mispredict;
  assign branch_is_taken_o     = out_valid_q && out_q.taken;
  assign branch_is_not_taken_o = out_valid_q && !out_q.taken;
  assign branch_source_o       = out_q.source;
  assign branch_pc_o           = out_q.target;
  assign branch_is_call_o      = out_valid_q && out_q.is_call;
  assign branch_is_ret_o       = out_valid_q && out_q.is_ret;
  assign branch_is_jmp_o       = out_valid_q && out_q.is_jmp;
  assign mispredict_count_o    = mispredict_count_q;

endmodule

// File: tb/tb_biriscv_branch_resolve.sv
// Bench for biriscv_branch_resolve: directed scenarios plus random traffic,
// compared each cycle against a queue-based model of the training stream.
module tb_biriscv_branch_resolve;

  localparam int DEPTH   = 4;
  localparam int DEPTH_W = 2;
  localparam int W       = 69;

  logic        clk_i = 1'b0;
  logic        rst_i;
  logic        flush_i;
  logic        res_a_valid_i, res_b_valid_i;
  logic [31:0] res_a_source_i, res_b_source_i;
  logic [31:0] res_a_target_i, res_b_target_i;
  logic        res_a_taken_i, res_b_taken_i;
  logic        res_a_pred_taken_i, res_b_pred_taken_i;
  logic [31:0] res_a_pred_target_i, res_b_pred_target_i;
  logic        res_a_is_call_i, res_b_is_call_i;
  logic        res_a_is_ret_i, res_b_is_ret_i;
  logic        res_a_is_jmp_i, res_b_is_jmp_i;
  logic        stall_o, redirect_o;
  logic [31:0] redirect_pc_o;
  logic        branch_request_o, branch_is_taken_o, branch_is_not_taken_o;
  logic [31:0] branch_source_o, branch_pc_o;
  logic        branch_is_call_o, branch_is_ret_o, branch_is_jmp_o;
  logic [31:0] mispredict_count_o;

  // clock / reset
  always #5 clk_i = ~clk_i;

  biriscv_branch_resolve #(.DEPTH(DEPTH), .DEPTH_W(DEPTH_W)) dut (
    .clk_i(clk_i), .rst_i(rst_i), .flush_i(flush_i),
    .res_a_valid_i(res_a_valid_i), .res_a_source_i(res_a_source_i),
    .res_a_target_i(res_a_target_i), .res_a_taken_i(res_a_taken_i),
    .res_a_pred_taken_i(res_a_pred_taken_i), .res_a_pred_target_i(res_a_pred_target_i),
    .res_a_is_call_i(res_a_is_call_i), .res_a_is_ret_i(res_a_is_ret_i),
    .res_a_is_jmp_i(res_a_is_jmp_i),
    .res_b_valid_i(res_b_valid_i), .res_b_source_i(res_b_source_i),
    .res_b_target_i(res_b_target_i), .res_b_taken_i(res_b_taken_i),
    .res_b_pred_taken_i(res_b_pred_taken_i), .res_b_pred_target_i(res_b_pred_target_i),
    .res_b_is_call_i(res_b_is_call_i), .res_b_is_ret_i(res_b_is_ret_i),
    .res_b_is_jmp_i(res_b_is_jmp_i),
    .stall_o(stall_o), .redirect_o(redirect_o), .redirect_pc_o(redirect_pc_o),
    .branch_request_o(branch_request_o), .branch_is_taken_o(branch_is_taken_o),
    .branch_is_not_taken_o(branch_is_not_taken_o),
    .branch_source_o(branch_source_o), .branch_pc_o(branch_pc_o),
    .branch_is_call_o(branch_is_call_o), .branch_is_ret_o(branch_is_ret_o),
    .branch_is_jmp_o(branch_is_jmp_o), .mispredict_count_o(mispredict_count_o)
  );

  // scoreboard: entries accepted but not yet emitted, plus what is on the outputs
  int              total = 0;
  int              bad   = 0;
  logic [W-1:0]    exp_q[$];
  bit              m_emit;
  logic [W-1:0]    m_ent;
  bit              m_redir;
  logic [31:0]     m_redir_pc;
  logic [31:0]     m_count;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  function automatic bit f_misp(input bit tk, input bit ptk,
                                input logic [31:0] tgt, input logic [31:0] ptgt);
    return (tk != ptk) || (tk && (tgt != ptgt));
  endfunction

  // driver tasks
  task automatic set_pipe(input bit p, input bit v, input logic [31:0] src,
                          input logic [31:0] tgt, input bit tk, input bit ptk,
                          input logic [31:0] ptgt, input bit c, input bit r, input bit j);
    if (!p) begin
      res_a_valid_i = v; res_a_source_i = src; res_a_target_i = tgt;
      res_a_taken_i = tk; res_a_pred_taken_i = ptk; res_a_pred_target_i = ptgt;
      res_a_is_call_i = c; res_a_is_ret_i = r; res_a_is_jmp_i = j;
    end else begin
      res_b_valid_i = v; res_b_source_i = src; res_b_target_i = tgt;
      res_b_taken_i = tk; res_b_pred_taken_i = ptk; res_b_pred_target_i = ptgt;
      res_b_is_call_i = c; res_b_is_ret_i = r; res_b_is_jmp_i = j;
    end
  endtask

  task automatic idle();
    flush_i = 1'b0;
    set_pipe(1'b0, 1'b0, '0, '0, 1'b0, 1'b0, '0, 1'b0, 1'b0, 1'b0);
    set_pipe(1'b1, 1'b0, '0, '0, 1'b0, 1'b0, '0, 1'b0, 1'b0, 1'b0);
  endtask

  task automatic model_reset();
    exp_q.delete();
    m_emit = 0; m_ent = '0; m_redir = 0; m_redir_pc = '0; m_count = '0;
  endtask

  // Apply the current inputs to the model as of the coming rising edge.
  task automatic model_update();
    logic [W-1:0] acc[$];
    bit           stall, ma, mb, rd;
    logic [31:0]  rpc;
    stall = exp_q.size() > DEPTH - 2;
    ma = f_misp(res_a_taken_i, res_a_pred_taken_i, res_a_target_i, res_a_pred_target_i);
    mb = f_misp(res_b_taken_i, res_b_pred_taken_i, res_b_target_i, res_b_pred_target_i);
    rd = 0; rpc = '0;
    if (!flush_i && !stall) begin
      if (res_a_valid_i) begin
        acc.push_back({res_a_source_i, res_a_target_i, res_a_taken_i, ma,
                       res_a_is_call_i, res_a_is_ret_i, res_a_is_jmp_i});
        if (ma) begin
          rd = 1; rpc = res_a_taken_i ? res_a_target_i : res_a_source_i + 32'd4;
        end
      end
      if (res_b_valid_i && !(res_a_valid_i && ma)) begin
        acc.push_back({res_b_source_i, res_b_target_i, res_b_taken_i, mb,
                       res_b_is_call_i, res_b_is_ret_i, res_b_is_jmp_i});
        if (mb && !rd) begin
          rd = 1; rpc = res_b_taken_i ? res_b_target_i : res_b_source_i + 32'd4;
        end
      end
    end
    m_redir = rd;
    if (rd) m_redir_pc = rpc;
    if (rd && m_count != 32'hFFFF_FFFF) m_count = m_count + 32'd1;
    if (flush_i) begin
      exp_q.delete();
      m_emit = 0;
    end else begin
      foreach (acc[i]) exp_q.push_back(acc[i]);
      if (exp_q.size() > 0) begin
        m_ent  = exp_q.pop_front();
        m_emit = 1;
      end else begin
        m_emit = 0;
      end
    end
  endtask

  task automatic check_outputs();
    check("is_taken", branch_is_taken_o, m_emit & m_ent[4]);
    check("is_not_taken", branch_is_not_taken_o, m_emit & ~m_ent[4]);
    check("request", branch_request_o, m_emit & m_ent[3]);
    check("is_call", branch_is_call_o, m_emit & m_ent[2]);
    check("is_ret", branch_is_ret_o, m_emit & m_ent[1]);
    check("is_jmp", branch_is_jmp_o, m_emit & m_ent[0]);
    check("source", branch_source_o, m_ent[68:37]);
    check("pc", branch_pc_o, m_ent[36:5]);
    check("redirect", redirect_o, m_redir);
    if (m_redir) check("redirect_pc", redirect_pc_o, m_redir_pc);
    check("count", mispredict_count_o, m_count);
    check("stall", stall_o, exp_q.size() > DEPTH - 2);
  endtask

  task automatic cycle();
    model_update();
    @(negedge clk_i);
    idle();
    check_outputs();
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, "_strobes"}, {branch_request_o, branch_is_taken_o, branch_is_not_taken_o,
                              branch_is_call_o, branch_is_ret_o, branch_is_jmp_o}, 0);
    check({tag, "_redirect"}, {redirect_o, redirect_pc_o}, 0);
    check({tag, "_data"}, {branch_source_o, branch_pc_o}, 0);
    check({tag, "_count"}, mispredict_count_o, 0);
    check({tag, "_stall"}, stall_o, 0);
  endtask

  task automatic drive_dual(input logic [31:0] base);
    set_pipe(1'b0, 1'b1, base, base + 32'h100, 1'b1, 1'b1, base + 32'h100, 1'b0, 1'b0, 1'b0);
    set_pipe(1'b1, 1'b1, base + 32'h8, base + 32'h200, 1'b0, 1'b0, 32'h0, 1'b0, 1'b0, 1'b0);
  endtask

  initial begin
    logic [31:0] seen[$];
    bit          saw_stall;
    int          k;

    rst_i = 1'b1;
    idle();
    model_reset();
    repeat (2) @(negedge clk_i);
    check_all_zero("reset");
    rst_i = 1'b0;
    cycle();

    // single correct taken branch
    set_pipe(1'b0, 1'b1, 32'h1000, 32'h2000, 1'b1, 1'b1, 32'h2000, 1'b0, 1'b0, 1'b0);
    cycle();
    check("t1_taken", branch_is_taken_o, 1);
    check("t1_request", branch_request_o, 0);
    check("t1_src", branch_source_o, 32'h1000);
    check("t1_pc", branch_pc_o, 32'h2000);
    check("t1_redirect", redirect_o, 0);

    // not-taken predicted taken
    set_pipe(1'b0, 1'b1, 32'h1000, 32'h5000, 1'b0, 1'b1, 32'h5000, 1'b0, 1'b0, 1'b1);
    cycle();
    check("t2_redirect", redirect_o, 1);
    check("t2_redirect_pc", redirect_pc_o, 32'h1004);
    check("t2_request", branch_request_o, 1);
    check("t2_not_taken", branch_is_not_taken_o, 1);
    check("t2_count", mispredict_count_o, 1);
    cycle();
    check("t2_pulse", redirect_o, 0);

    // A mispredicts, younger B must vanish
    set_pipe(1'b0, 1'b1, 32'h1100, 32'h1800, 1'b0, 1'b1, 32'h1800, 1'b1, 1'b0, 1'b0);
    set_pipe(1'b1, 1'b1, 32'h1200, 32'h1300, 1'b1, 1'b1, 32'h1300, 1'b0, 1'b0, 1'b0);
    cycle();
    check("t3_a_src", branch_source_o, 32'h1100);
    cycle();
    check("t3_b_dropped", branch_is_taken_o | branch_is_not_taken_o, 0);
    check("t3_count", mispredict_count_o, 2);

    // dual-issue burst into a depth-4 FIFO
    k = 0; saw_stall = 0;
    for (int c = 0; c < 16; c++) begin
      if (stall_o) saw_stall = 1;
      if (k < 4 && !(exp_q.size() > DEPTH - 2)) begin
        drive_dual(32'h4000 + 32'(k) * 32'h10);
        k++;
      end
      cycle();
      if (branch_is_taken_o | branch_is_not_taken_o) seen.push_back(branch_source_o);
    end
    check("t4_stall_seen", saw_stall, 1);
    check("t4_n_emitted", seen.size(), 8);
    for (int i = 0; i < 8; i++) begin
      logic [31:0] want;
      want = 32'h4000 + 32'(i / 2) * 32'h10 + ((i % 2) ? 32'h8 : 32'h0);
      check("t4_order", (i < seen.size()) ? seen[i] : 32'hDEAD_BEEF, want);
    end

    // flush with three queued, plus a mispredict offered in the flush cycle
    for (int c = 0; c < 6 && exp_q.size() < 3; c++) begin
      drive_dual(32'h5000 + 32'(c) * 32'h10);
      cycle();
    end
    check("t5_queued", exp_q.size(), 3);
    flush_i = 1'b1;
    set_pipe(1'b0, 1'b1, 32'h5800, 32'h5900, 1'b1, 1'b0, 32'h0, 1'b0, 1'b0, 1'b0);
    cycle();
    check("t5_no_emit", branch_is_taken_o | branch_is_not_taken_o, 0);
    check("t5_stall", stall_o, 0);
    check("t5_no_redirect", redirect_o, 0);
    repeat (2) begin
      cycle();
      check("t5_quiet", branch_is_taken_o | branch_is_not_taken_o, 0);
    end

    // target-only mispredict
    set_pipe(1'b0, 1'b1, 32'h6000, 32'h3000, 1'b1, 1'b1, 32'h2000, 1'b0, 1'b0, 1'b0);
    cycle();
    check("t6_redirect_pc", redirect_pc_o, 32'h3000);
    check("t6_request", branch_request_o, 1);

    // random traffic, occasional flushes and stall violations
    for (int c = 0; c < 1500; c++) begin
      bit          viol, stall_m;
      logic [31:0] tgt;
      bit          tk;
      stall_m = exp_q.size() > DEPTH - 2;
      viol = ($urandom_range(0, 15) == 0);
      for (int p = 0; p < 2; p++) begin
        tk  = $urandom_range(0, 1);
        tgt = {$urandom_range(0, 32'hFFFF), 16'h0} | (32'($urandom_range(0, 255)) << 2);
        set_pipe(p[0], ($urandom_range(0, 99) < 55) && (!stall_m || viol),
                 {$urandom(), 2'b00} >> 2 << 2, tgt, tk,
                 ($urandom_range(0, 3) == 0) ? !tk : tk,
                 ($urandom_range(0, 5) == 0) ? tgt ^ 32'h10 : tgt,
                 $urandom_range(0, 1), $urandom_range(0, 1), $urandom_range(0, 1));
      end
      flush_i = ($urandom_range(0, 49) == 0);
      cycle();
    end

    // saturation of the mispredict counter
    force dut.mispredict_count_q = 32'hFFFF_FFFE;
    #1 release dut.mispredict_count_q;
    m_count = 32'hFFFF_FFFE;
    cycle();
    check("sat_preload", mispredict_count_o, 32'hFFFF_FFFE);
    repeat (3) begin
      if (!stall_o)
        set_pipe(1'b0, 1'b1, 32'h7000, 32'h7100, 1'b0, 1'b1, 32'h7100, 1'b0, 1'b0, 1'b0);
      cycle();
    end
    check("sat_count", mispredict_count_o, 32'hFFFF_FFFF);

    // asynchronous reset in the middle of a burst
    drive_dual(32'h8000);
    cycle();
    drive_dual(32'h8100);
    #2 rst_i = 1'b1;
    #1 check_all_zero("async_reset");
    idle();
    @(negedge clk_i);
    rst_i = 1'b0;
    model_reset();
    repeat (4) begin
      cycle();
      check("post_reset_quiet", branch_is_taken_o | branch_is_not_taken_o, 0);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
